fp_add_arbiter: RTL and testbench

//  Shares one fully pipelined FP32 add unit (swap/align/add/normalize path) between two requesters.

---
 rtl/fp_add_pkg.sv | 9 +
 rtl/fp_add_tag_pipe.sv | 31 +++
 rtl/fp_add_arbiter.sv | 97 +++++++++
 tb/tb_fp_add_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared types and constants for the FP32 adder arbiter
package fp_add_pkg;
  localparam int FP32_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} arb_state_t;
  typedef struct packed {
    logic vld;
    logic owner;
  } arb_tag_t;
endpackage

// File: rtl/fp_add_tag_pipe.sv
// fp_add_tag_pipe: fixed-depth shift register tracking owner of each in-flight add
module fp_add_tag_pipe
  import fp_add_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type T     = arb_tag_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  T     i_tag,
  output T     o_tail,
  output logic o_empty
);
  T r_pipe [DEPTH];
  // shift one stage per cycle; an empty slot is inserted when nothing issues
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= i_push ? i_tag : '0;
      for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end
  // pipe is empty when no stage holds a live tag
  always_comb begin
    o_empty = 1'b1;
    for (int k = 0; k < DEPTH; k++) if (r_pipe[k] != '0) o_empty = 1'b0;
  end
  assign o_tail = r_pipe[DEPTH-1];
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one pipelined FP32 adder by two requesters; FP_ARB_STATS_EN adds grant counters
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int SIZE_DATA = FP32_W,
  parameter int ADD_LAT   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid_0,
  input  logic                 i_valid_1,
  input  logic [SIZE_DATA-1:0] i_a_0,
  input  logic [SIZE_DATA-1:0] i_b_0,
  input  logic [SIZE_DATA-1:0] i_a_1,
  input  logic [SIZE_DATA-1:0] i_b_1,
  output logic                 o_ready_0,
  output logic                 o_ready_1,
  output logic                 o_add_valid,
  output logic [SIZE_DATA-1:0] o_add_a,
  output logic [SIZE_DATA-1:0] o_add_b,
  input  logic                 i_add_valid,
  input  logic [SIZE_DATA-1:0] i_add_result,
  output logic                 o_res_valid_0,
  output logic                 o_res_valid_1,
  output logic [SIZE_DATA-1:0] o_res,
  input  logic                 i_flush,
  output logic                 o_idle,
`ifdef FP_ARB_STATS_EN
  output logic [CNT_W-1:0]     o_cnt_0,
  output logic [CNT_W-1:0]     o_cnt_1,
`endif
  output logic                 o_err
);
  arb_state_t r_state, w_next;
  logic       r_rr, r_ran, r_err;
  logic       w_gnt_0, w_gnt_1, w_empty;
  arb_tag_t   w_tail;
  // next state and grant; nothing is granted in the cycle flush is seen
  always_comb begin
    w_next  = r_state;
    w_gnt_0 = 1'b0;
    w_gnt_1 = 1'b0;
    w_next  = (r_state == IDLE) ? (i_flush ? IDLE : RUN) :
              (r_state == RUN)  ? (i_flush ? DRAIN : RUN) :
              (w_empty ? IDLE : DRAIN);
    w_gnt_0 = (r_state == RUN) && !i_flush && i_valid_0 && (!i_valid_1 || !r_rr);
    w_gnt_1 = (r_state == RUN) && !i_flush && i_valid_1 && (!i_valid_0 || r_rr);
  end
  // state, round-robin pointer, first-run marker and sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_ran   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rr    <= (i_valid_0 && i_valid_1 && (w_gnt_0 || w_gnt_1)) ? !r_rr : r_rr;
      r_ran   <= r_ran || (r_state == RUN);
      r_err   <= r_err || (i_add_valid != w_tail.vld);
    end
  end
  fp_add_tag_pipe #(.DEPTH(ADD_LAT), .T(arb_tag_t)) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (o_add_valid),
    .i_tag   ('{vld: 1'b1, owner: w_gnt_1}),
    .o_tail  (w_tail),
    .o_empty (w_empty)
  );
  assign o_ready_0     = w_gnt_0;
  assign o_ready_1     = w_gnt_1;
  assign o_add_valid   = w_gnt_0 || w_gnt_1;
  assign o_add_a       = w_gnt_0 ? i_a_0 : w_gnt_1 ? i_a_1 : '0;
  assign o_add_b       = w_gnt_0 ? i_b_0 : w_gnt_1 ? i_b_1 : '0;
  assign o_res_valid_0 = w_tail.vld && !w_tail.owner;
  assign o_res_valid_1 = w_tail.vld && w_tail.owner;
  assign o_res         = w_tail.vld ? i_add_result : '0;
  assign o_idle        = (r_state == IDLE) && r_ran;
  assign o_err         = r_err;
`ifdef FP_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt_0, r_cnt_1;
  // saturating per-requester grant counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_0 <= '0;
      r_cnt_1 <= '0;
    end else begin
      r_cnt_0 <= r_cnt_0 + CNT_W'(w_gnt_0 && !(&r_cnt_0));
      r_cnt_1 <= r_cnt_1 + CNT_W'(w_gnt_1 && !(&r_cnt_1));
    end
  end
  assign o_cnt_0 = r_cnt_0;
  assign o_cnt_1 = r_cnt_1;
`endif
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed scoreboard bench for fp_add_arbiter with a stand-in adder (a+b)
module tb_fp_add_arbiter;
  import fp_add_pkg::*;
  localparam int LAT = 3;
`ifdef FP_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n;
  logic        i_valid_0, i_valid_1, i_flush, i_add_valid, inj_r;
  logic [31:0] i_a_0, i_b_0, i_a_1, i_b_1, i_add_result;
  logic        o_ready_0, o_ready_1, o_add_valid, o_res_valid_0, o_res_valid_1, o_idle, o_err;
  logic [31:0] o_add_a, o_add_b, o_res;
`ifdef FP_ARB_STATS_EN
  logic [CW-1:0] o_cnt_0, o_cnt_1;
`endif
  logic [LAT-1:0] r_av;
  logic [31:0]    r_ar [LAT];

  exp_t       q[$];
  int         n_err = 0, n_chk = 0, n = 0, m_c0 = 0, m_c1 = 0;
  arb_state_t m_state;
  logic       m_rr, m_ran, m_err;

  fp_add_arbiter #(.SIZE_DATA(32), .ADD_LAT(LAT), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid_0(i_valid_0), .i_valid_1(i_valid_1),
    .i_a_0(i_a_0), .i_b_0(i_b_0), .i_a_1(i_a_1), .i_b_1(i_b_1),
    .o_ready_0(o_ready_0), .o_ready_1(o_ready_1),
    .o_add_valid(o_add_valid), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .i_add_valid(i_add_valid), .i_add_result(i_add_result),
    .o_res_valid_0(o_res_valid_0), .o_res_valid_1(o_res_valid_1), .o_res(o_res),
    .i_flush(i_flush), .o_idle(o_idle),
`ifdef FP_ARB_STATS_EN
    .o_cnt_0(o_cnt_0), .o_cnt_1(o_cnt_1),
`endif
    .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in adder: fixed latency, result is the integer sum of the operands
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_av <= '0;
      for (int k = 0; k < LAT; k++) r_ar[k] <= '0;
    end else begin
      r_av    <= {r_av[LAT-2:0], o_add_valid};
      r_ar[0] <= o_add_a + o_add_b;
      for (int k = 1; k < LAT; k++) r_ar[k] <= r_ar[k-1];
    end
  end
  assign i_add_valid  = r_av[LAT-1] | inj_r;
  assign i_add_result = r_ar[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready_0", o_ready_0, 0);
    chk("rst_ready_1", o_ready_1, 0);
    chk("rst_add_valid", o_add_valid, 0);
    chk("rst_add_a", o_add_a, 0);
    chk("rst_res_valid_0", o_res_valid_0, 0);
    chk("rst_res_valid_1", o_res_valid_1, 0);
    chk("rst_res", o_res, 0);
    chk("rst_idle", o_idle, 0);
    chk("rst_err", o_err, 0);
`ifdef FP_ARB_STATS_EN
    chk("rst_cnt_0", o_cnt_0, 0);
    chk("rst_cnt_1", o_cnt_1, 0);
`endif
    q.delete();
    m_state = IDLE; m_rr = 0; m_ran = 0; m_err = 0; m_c0 = 0; m_c1 = 0;
    i_valid_0 = 0; i_valid_1 = 0; i_flush = 1; inj_r = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // one cycle: drive, check combinational outputs and due results, advance the model
  task automatic cyc(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                     input logic fl, input logic inj);
    logic g0, g1, run, emp, pulse;
    exp_t e;
    @(negedge clk);
    i_valid_0 = v0; i_a_0 = a0; i_b_0 = b0;
    i_valid_1 = v1; i_a_1 = a1; i_b_1 = b1;
    i_flush = fl; inj_r = inj;
    #1;
    emp = (q.size() == 0);
    run = (m_state == RUN) && !fl;
    g0 = run && v0 && (!v1 || !m_rr);
    g1 = run && v1 && (!v0 || m_rr);
    chk("ready_0", o_ready_0, g0);
    chk("ready_1", o_ready_1, g1);
    chk("add_valid", o_add_valid, g0 | g1);
    chk("add_a", o_add_a, g0 ? a0 : g1 ? a1 : 0);
    chk("add_b", o_add_b, g0 ? b0 : g1 ? b1 : 0);
    pulse = !emp && q[0].due == n;
    e = '{0, 1'b0, 32'h0};
    if (pulse) e = q.pop_front();
    chk("res_valid_0", o_res_valid_0, pulse && !e.owner);
    chk("res_valid_1", o_res_valid_1, pulse && e.owner);
    chk("res", o_res, pulse ? e.data : 0);
    chk("idle", o_idle, (m_state == IDLE) && m_ran);
    chk("err", o_err, m_err);
`ifdef FP_ARB_STATS_EN
    chk("cnt_0", o_cnt_0, m_c0);
    chk("cnt_1", o_cnt_1, m_c1);
`endif
    if (g0 || g1) q.push_back('{n + LAT, g1, g0 ? a0 + b0 : a1 + b1});
    if (v0 && v1 && (g0 || g1)) m_rr = !m_rr;
    if (g0 && m_c0 < (1 << CW) - 1) m_c0++;
    if (g1 && m_c1 < (1 << CW) - 1) m_c1++;
    if (inj && !pulse) m_err = 1;
    m_state = (m_state == IDLE) ? (fl ? IDLE : RUN) :
              (m_state == RUN)  ? (fl ? DRAIN : RUN) : (emp ? IDLE : DRAIN);
    if (m_state == RUN) m_ran = 1;
    n++;
  endtask

  initial begin
    rst_n = 0; i_valid_0 = 0; i_valid_1 = 0; i_flush = 1; inj_r = 0;
    i_a_0 = 0; i_b_0 = 0; i_a_1 = 0; i_b_1 = 0;
    do_reset();
    // IDLE holds under flush, then a single requester
    cyc(1, 1, 2, 1, 3, 4, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // both requesting: alternating grants, results in order
    for (int i = 0; i < 6; i++) cyc(1, $urandom(), $urandom(), 1, $urandom(), $urandom(), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // drain with three in flight, then resume
    for (int i = 0; i < 3; i++) cyc(1, $urandom(), $urandom(), 1, $urandom(), $urandom(), 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, $urandom(), $urandom(), 1, $urandom(), $urandom(), 1, 0);
    chk("drain_idle", o_idle, 1);
    cyc(0, 0, 0, 1, 5, 6, 0, 0);
    cyc(0, 0, 0, 1, 7, 8, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // spurious adder strobe sets sticky error
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, $urandom(), $urandom(), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", o_err, 1);
    // reset with two ops in flight: nothing comes back
    cyc(1, $urandom(), $urandom(), 1, $urandom(), $urandom(), 0, 0);
    cyc(1, $urandom(), $urandom(), 1, $urandom(), $urandom(), 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // long single-requester run (saturates counters when enabled)
    for (int i = 0; i < 20; i++) cyc(1, $urandom(), $urandom(), 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FP_ARB_STATS_EN
    chk("cnt_0_sat", o_cnt_0, 15);
    chk("cnt_1_zero", o_cnt_1, 0);
`endif
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
